jump_ctrl: RTL and testbench
============================

// Module: jump_ctrl
// PURPOSE
//  Drives the program counter's jump interface (jump_en, abs_jump, target) from decoded branch ops.
//  Branch targets/offsets come from a loadable target LUT indexed by instruction field br_idx.
//  CALL/RET use an internal return-address stack (RAS). Sits between decoder/ALU flags and the PC.
//  Jump outputs are combinational in the op cycle; the PC consumes them at the next posedge.
// PARAMETERS
//  D   12  PC / target width (must equal the PC's D)
//  LW  5   LUT index width; 2**LW entries of D bits
//  SD  4   RAS depth (entries), >=2
// PORTS
//  clk        in   1      clock
//  reset      in   1      synchronous, active-high
//  prog_ctr   in   D      current PC value
//  br_op      in   3      branch op (br_op_t)
//  br_idx     in   LW     target LUT index
//  cond       in   1      branch condition flag from ALU
//  lut_we     in   1      LUT write enable (program load)
//  lut_waddr  in   LW     LUT write index
//  lut_wdata  in   D      LUT write data
//  jump_en    out  1      to PC jump_en
//  abs_jump   out  1      to PC abs_jump (1=absolute, 0=relative)
//  target     out  D      to PC target
//  ras_depth  out  $clog2(SD+1)  current RAS occupancy
//  ras_ovf    out  1      sticky: CALL attempted with RAS full
//  ras_unf    out  1      sticky: RET attempted with RAS empty
// BEHAVIOUR
//  Reset: RAS pointer=0, ras_depth=0, ras_ovf=ras_unf=0, all LUT entries=0; jump_en=0 while reset high.
//  br_op: NOP=0, BRC_REL=1, BRC_ABS=2, JMP=3, CALL=4, RET=5; 6,7 reserved -> treat as NOP.
//  Let L = lut[br_idx] (combinational read).
//  NOP:     jump_en=0, abs_jump=0, target=0.
//  BRC_REL: jump_en=cond, abs_jump=0, target=L (two's-complement offset; PC adds mod 2**D).
//  BRC_ABS: jump_en=cond, abs_jump=1, target=L.
//  JMP:     jump_en=1, abs_jump=1, target=L.
//  CALL:    not full: push prog_ctr+1 (mod 2**D, so 2**D-1 wraps to 0); jump_en=1, abs_jump=1, target=L.
//           full: no push, jump_en=0 (fall through), ras_ovf<=1.
//  RET:     not empty: pop; jump_en=1, abs_jump=1, target=top entry.
//           empty: jump_en=0, target=0, ras_unf<=1.
//  Push/pop, depth and sticky-flag updates commit at the posedge ending the op cycle. One op per cycle.
//  ras_ovf/ras_unf clear only on reset.
//  LUT write: commits at posedge. A same-cycle read of lut_waddr returns the OLD value.
//  LUT writes are independent of br_op and may coincide with any op.
//  Reset mid-operation: reset wins. Any CALL/RET in the reset cycle has no effect on the RAS.
//  Outputs are purely combinational from inputs and state. No registered latency on the jump path.
// STRUCTURE
//  Package jump_pkg: br_op_t enum (values above), localparam BR_OP_W=3.
//  Sub-module jump_lut (2**LW x D, 1 sync write port, 1 async read port, sync reset to 0).
//  RAS, pointer and flags live in jump_ctrl.
// TESTING
//  After reset, load lut[3]=12'h040, lut[4]=12'hFFE.
//  JMP idx3 -> jump_en=1, abs=1, target=040.
//  BRC_REL idx4, cond=1 -> jump_en=1, abs=0, target=FFE (PC 010 -> 00E).
//  With cond=0 -> jump_en=0.
//  At prog_ctr=010, CALL idx3 -> target=040, depth=1.
//  Then at 045, RET -> jump_en=1, abs=1, target=011, depth=0.
//  Do SD CALLs, then one more CALL -> jump_en=0, ras_ovf=1, depth=SD.
//  Then SD RETs -> targets pop in LIFO order.
//  RET on empty RAS -> jump_en=0, ras_unf=1. Flag holds until reset.
//  CALL at prog_ctr=FFF -> pushed return address 000; subsequent RET target=000.
//  Same-cycle lut_we to idx3=0x100 with JMP idx3 -> target=040; next-cycle JMP idx3 -> 100.
//  Assert reset during a CALL with depth 2 -> next cycle depth=0, flags=0, jump_en=0 during reset.

Source files
------------

// File: rtl/jump_pkg.sv
// Purpose: shared definitions for the jump controller slice.
//   BR_OP_W : width of the decoded branch-op field
//   br_op_t : branch op encoding; codes 6 and 7 are reserved and behave as NOP
package jump_pkg;

  localparam int BR_OP_W = 3;

  typedef enum logic [BR_OP_W-1:0] {
    BR_NOP     = 3'd0,
    BR_BRC_REL = 3'd1,
    BR_BRC_ABS = 3'd2,
    BR_JMP     = 3'd3,
    BR_CALL    = 3'd4,
    BR_RET     = 3'd5
  } br_op_t;

endpackage

// File: rtl/jump_ctrl_if.sv
// Purpose: bundles the decoder/ALU-side inputs and the PC-side jump outputs
// of the jump controller.
//   master : decoder / program loader side (drives op, index, cond, LUT writes)
//   slave  : jump_ctrl side (drives jump_en, abs_jump, target, RAS status)
// Signals:
//   prog_ctr [D]    current PC          br_op [3]     branch op
//   br_idx   [LW]   target LUT index    cond          ALU condition flag
//   lut_we          LUT write enable    lut_waddr/lut_wdata  LUT write port
//   jump_en, abs_jump, target [D]       jump request to the PC
//   ras_depth [$clog2(SD+1)]            RAS occupancy
//   ras_ovf, ras_unf                    sticky RAS overflow/underflow flags
interface jump_ctrl_if #(
  parameter int D  = 12,
  parameter int LW = 5,
  parameter int SD = 4
);
  import jump_pkg::*;

  localparam int DW = $clog2(SD + 1);

  logic [D-1:0]       prog_ctr;
  logic [BR_OP_W-1:0] br_op;
  logic [LW-1:0]      br_idx;
  logic               cond;
  logic               lut_we;
  logic [LW-1:0]      lut_waddr;
  logic [D-1:0]       lut_wdata;
  logic               jump_en;
  logic               abs_jump;
  logic [D-1:0]       target;
  logic [DW-1:0]      ras_depth;
  logic               ras_ovf;
  logic               ras_unf;

  modport master (
    output prog_ctr, br_op, br_idx, cond, lut_we, lut_waddr, lut_wdata,
    input  jump_en, abs_jump, target, ras_depth, ras_ovf, ras_unf
  );

  modport slave (
    input  prog_ctr, br_op, br_idx, cond, lut_we, lut_waddr, lut_wdata,
    output jump_en, abs_jump, target, ras_depth, ras_ovf, ras_unf
  );

endinterface

// File: rtl/jump_lut.sv
// Purpose: branch target / offset table, 2**LW entries of D bits.
//   clk, reset : clock, synchronous active-high reset (clears every entry)
//   we_i, waddr_i, wdata_i : synchronous write port
//   raddr_i, rdata_o       : asynchronous read port; a read of an address
//                            being written in the same cycle sees the old data
module jump_lut #(
  parameter int D  = 12,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [LW-1:0] waddr_i,
  input  logic [D-1:0]  wdata_i,
  input  logic [LW-1:0] raddr_i,
  output logic [D-1:0]  rdata_o
);

  localparam int N = 2 ** LW;

  logic [D-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/jump_ctrl.sv
// Purpose: turns decoded branch ops into a jump request for the program
// counter. Targets/offsets come from jump_lut; CALL/RET use an internal
// return-address stack (RAS). The jump path is purely combinational so the
// PC can act on it at the posedge that ends the op cycle.
//   clk, reset : clock, synchronous active-high reset
//   bus        : jump_ctrl_if slave modport (op inputs, LUT write port,
//                jump outputs, RAS depth and sticky overflow/underflow flags)
module jump_ctrl
  import jump_pkg::*;
#(
  parameter int D  = 12,
  parameter int LW = 5,
  parameter int SD = 4
) (
  input  logic      clk,
  input  logic      reset,
  jump_ctrl_if.slave bus
);

  localparam int DW = $clog2(SD + 1);
  localparam int PW = $clog2(SD);

  br_op_t        op;
  logic [D-1:0]  lut_rd;
  logic [D-1:0]  ras_q [SD];
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          push;
  logic          full, empty;
  logic [PW-1:0] wr_ptr, top_ptr;
  logic          jump_en, abs_jump;
  logic [D-1:0]  target;

  // Return address wraps modulo 2**D, so a CALL at the last address returns to 0.
  function automatic logic [D-1:0] ret_addr(input logic [D-1:0] pc);
    return pc + D'(1);
  endfunction

  jump_lut #(.D(D), .LW(LW)) u_lut (
    .clk     (clk),
    .reset   (reset),
    .we_i    (bus.lut_we),
    .waddr_i (bus.lut_waddr),
    .wdata_i (bus.lut_wdata),
    .raddr_i (bus.br_idx),
    .rdata_o (lut_rd)
  );

  assign op      = br_op_t'(bus.br_op);
  assign full    = (depth_q == DW'(SD));
  assign empty   = (depth_q == '0);
  // depth_q doubles as the stack pointer: next free slot, top is one below.
  assign wr_ptr  = PW'(depth_q);
  assign top_ptr = PW'(depth_q - DW'(1));

  always_comb begin
    jump_en  = 1'b0;
    abs_jump = 1'b0;
    target   = '0;
    push     = 1'b0;
    depth_d  = depth_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    case (op)
      BR_BRC_REL: begin
        jump_en = bus.cond;
        target  = lut_rd;
      end
      BR_BRC_ABS: begin
        jump_en  = bus.cond;
        abs_jump = 1'b1;
        target   = lut_rd;
      end
      BR_JMP: begin
        jump_en  = 1'b1;
        abs_jump = 1'b1;
        target   = lut_rd;
      end
      BR_CALL: begin
        if (!full) begin
          jump_en  = 1'b1;
          abs_jump = 1'b1;
          target   = lut_rd;
          push     = 1'b1;
          depth_d  = depth_q + DW'(1);
        end else begin
          // Stack full: fall through without jumping and remember it.
          ovf_d = 1'b1;
        end
      end
      BR_RET: begin
        if (!empty) begin
          jump_en  = 1'b1;
          abs_jump = 1'b1;
          target   = ras_q[top_ptr];
          depth_d  = depth_q - DW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
      default: ;  // NOP and reserved codes
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage needs no reset; depth_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      ras_q[wr_ptr] <= ret_addr(bus.prog_ctr);
    end
  end

  assign bus.jump_en   = jump_en & ~reset;
  assign bus.abs_jump  = abs_jump;
  assign bus.target    = target;
  assign bus.ras_depth = depth_q;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Purpose: self-checking bench for jump_ctrl. A queue/array model tracks the
// LUT, return stack and sticky flags; a negedge compare process checks every
// output each cycle, and the directed sequence adds literal expectations.
module tb_jump_ctrl;
  import jump_pkg::*;

  localparam int D  = 12;
  localparam int LW = 5;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic reset;

  jump_ctrl_if #(.D(D), .LW(LW), .SD(SD)) bus ();

  jump_ctrl #(.D(D), .LW(LW), .SD(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model state
  logic [D-1:0] m_lut [2**LW];
  logic [D-1:0] m_stk [$];
  bit           m_ovf, m_unf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update at the clock edge, from the inputs of the cycle that ends.
  always @(posedge clk) begin
    if (reset) begin
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      for (int i = 0; i < 2**LW; i++) m_lut[i] = '0;
    end else begin
      if (bus.br_op == 3'd4) begin
        if (m_stk.size() < SD) m_stk.push_back(D'(bus.prog_ctr + 1));
        else m_ovf = 1'b1;
      end else if (bus.br_op == 3'd5) begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else m_unf = 1'b1;
      end
      if (bus.lut_we) m_lut[bus.lut_waddr] = bus.lut_wdata;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic         e_je, e_abs, e_av, e_tv;
    logic [D-1:0] e_tgt, L;
    e_je = 1'b0; e_abs = 1'b0; e_tgt = '0; e_av = 1'b1; e_tv = 1'b1;
    L = m_lut[bus.br_idx];
    case (bus.br_op)
      3'd1: begin e_je = bus.cond; e_tgt = L; end
      3'd2: begin e_je = bus.cond; e_abs = 1'b1; e_tgt = L; end
      3'd3: begin e_je = 1'b1; e_abs = 1'b1; e_tgt = L; end
      3'd4: begin
        if (m_stk.size() < SD) begin e_je = 1'b1; e_abs = 1'b1; e_tgt = L; end
        else begin e_av = 1'b0; e_tv = 1'b0; end
      end
      3'd5: begin
        if (m_stk.size() > 0) begin e_je = 1'b1; e_abs = 1'b1; e_tgt = m_stk[$]; end
        else e_av = 1'b0;
      end
      default: ;
    endcase
    if (reset) begin e_je = 1'b0; e_av = 1'b0; e_tv = 1'b0; end
    check("model jump_en", 32'(bus.jump_en), 32'(e_je));
    if (e_av) check("model abs_jump", 32'(bus.abs_jump), 32'(e_abs));
    if (e_tv) check("model target", 32'(bus.target), 32'(e_tgt));
    check("model ras_depth", 32'(bus.ras_depth), 32'(m_stk.size()));
    check("model ras_ovf", 32'(bus.ras_ovf), 32'(m_ovf));
    check("model ras_unf", 32'(bus.ras_unf), 32'(m_unf));
  end

  // Apply one cycle of inputs just after the edge, return at mid-cycle.
  task automatic drive(input logic rst, input logic [2:0] op, input logic [LW-1:0] idx,
                       input logic c, input logic [D-1:0] pc, input logic we,
                       input logic [LW-1:0] wa, input logic [D-1:0] wd);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.br_op     = op;
    bus.br_idx    = idx;
    bus.cond      = c;
    bus.prog_ctr  = pc;
    bus.lut_we    = we;
    bus.lut_waddr = wa;
    bus.lut_wdata = wd;
    @(negedge clk);
  endtask

  task automatic op_step(input logic [2:0] op, input logic [LW-1:0] idx,
                         input logic c, input logic [D-1:0] pc);
    drive(1'b0, op, idx, c, pc, 1'b0, '0, '0);
  endtask

  logic [D-1:0] ret_exp [SD];

  initial begin
    reset = 1'b1;
    bus.br_op = '0; bus.br_idx = '0; bus.cond = 1'b0; bus.prog_ctr = '0;
    bus.lut_we = 1'b0; bus.lut_waddr = '0; bus.lut_wdata = '0;

    // Reset with a JMP pending: no jump while reset is high.
    drive(1'b1, 3'd3, 5'd3, 1'b0, 12'h000, 1'b0, '0, '0);
    check("reset jump_en", 32'(bus.jump_en), 32'h0);
    check("reset depth", 32'(bus.ras_depth), 32'h0);
    check("reset ovf", 32'(bus.ras_ovf), 32'h0);
    check("reset unf", 32'(bus.ras_unf), 32'h0);

    // Program load
    drive(1'b0, 3'd0, 5'd0, 1'b0, 12'h000, 1'b1, 5'd3, 12'h040);
    check("nop target", 32'(bus.target), 32'h0);
    drive(1'b0, 3'd0, 5'd0, 1'b0, 12'h000, 1'b1, 5'd4, 12'hFFE);

    op_step(3'd3, 5'd3, 1'b0, 12'h000);
    check("jmp jump_en", 32'(bus.jump_en), 32'h1);
    check("jmp abs", 32'(bus.abs_jump), 32'h1);
    check("jmp target", 32'(bus.target), 32'h040);

    op_step(3'd1, 5'd4, 1'b1, 12'h010);
    check("brc_rel jump_en", 32'(bus.jump_en), 32'h1);
    check("brc_rel abs", 32'(bus.abs_jump), 32'h0);
    check("brc_rel target", 32'(bus.target), 32'hFFE);
    check("brc_rel new pc", 32'((bus.prog_ctr + bus.target) & 12'hFFF), 32'h00E);

    op_step(3'd1, 5'd4, 1'b0, 12'h010);
    check("brc_rel cond0", 32'(bus.jump_en), 32'h0);

    op_step(3'd2, 5'd3, 1'b1, 12'h010);
    check("brc_abs abs", 32'(bus.abs_jump), 32'h1);
    check("brc_abs target", 32'(bus.target), 32'h040);

    op_step(3'd4, 5'd3, 1'b0, 12'h010);
    check("call target", 32'(bus.target), 32'h040);
    op_step(3'd5, 5'd0, 1'b0, 12'h045);
    check("call depth", 32'(bus.ras_depth), 32'h1);
    check("ret jump_en", 32'(bus.jump_en), 32'h1);
    check("ret target", 32'(bus.target), 32'h011);
    op_step(3'd0, 5'd0, 1'b0, 12'h046);
    check("ret depth", 32'(bus.ras_depth), 32'h0);

    // Fill the stack, then overflow
    for (int i = 0; i < SD; i++) begin
      op_step(3'd4, 5'd3, 1'b0, D'((i + 1) * 256));
      ret_exp[i] = D'((i + 1) * 256 + 1);
    end
    op_step(3'd4, 5'd3, 1'b0, 12'h500);
    check("ovf call jump_en", 32'(bus.jump_en), 32'h0);
    op_step(3'd0, 5'd0, 1'b0, 12'h500);
    check("ovf flag", 32'(bus.ras_ovf), 32'h1);
    check("ovf depth", 32'(bus.ras_depth), 32'(SD));

    // Drain in LIFO order
    for (int i = SD - 1; i >= 0; i--) begin
      op_step(3'd5, 5'd0, 1'b0, 12'h600);
      check("lifo target", 32'(bus.target), 32'(ret_exp[i]));
    end
    check("lifo literal 101", 32'(ret_exp[0]), 32'h101);

    op_step(3'd5, 5'd0, 1'b0, 12'h600);
    check("unf ret jump_en", 32'(bus.jump_en), 32'h0);
    check("unf ret target", 32'(bus.target), 32'h0);
    op_step(3'd6, 5'd3, 1'b1, 12'h600);
    check("unf flag", 32'(bus.ras_unf), 32'h1);
    check("reserved6 jump_en", 32'(bus.jump_en), 32'h0);
    op_step(3'd7, 5'd3, 1'b1, 12'h600);
    check("reserved7 jump_en", 32'(bus.jump_en), 32'h0);
    check("unf sticky", 32'(bus.ras_unf), 32'h1);

    // Return-address wrap
    op_step(3'd4, 5'd3, 1'b0, 12'hFFF);
    check("wrap call jump_en", 32'(bus.jump_en), 32'h1);
    op_step(3'd5, 5'd0, 1'b0, 12'h040);
    check("wrap ret target", 32'(bus.target), 32'h000);
    check("wrap ret jump_en", 32'(bus.jump_en), 32'h1);

    // Same-cycle write returns old LUT data
    drive(1'b0, 3'd3, 5'd3, 1'b0, 12'h000, 1'b1, 5'd3, 12'h100);
    check("rdw old", 32'(bus.target), 32'h040);
    op_step(3'd3, 5'd3, 1'b0, 12'h000);
    check("rdw new", 32'(bus.target), 32'h100);

    // Reset during a CALL with depth 2
    op_step(3'd4, 5'd3, 1'b0, 12'h020);
    op_step(3'd4, 5'd3, 1'b0, 12'h030);
    drive(1'b1, 3'd4, 5'd3, 1'b0, 12'h040, 1'b0, '0, '0);
    check("rst call jump_en", 32'(bus.jump_en), 32'h0);
    check("rst call depth pre", 32'(bus.ras_depth), 32'h2);
    check("rst ovf pre", 32'(bus.ras_ovf), 32'h1);
    op_step(3'd0, 5'd0, 1'b0, 12'h000);
    check("post rst depth", 32'(bus.ras_depth), 32'h0);
    check("post rst ovf", 32'(bus.ras_ovf), 32'h0);
    check("post rst unf", 32'(bus.ras_unf), 32'h0);
    op_step(3'd3, 5'd3, 1'b0, 12'h000);
    check("post rst lut", 32'(bus.target), 32'h0);

    op_step(3'd0, 5'd0, 1'b0, 12'h000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
